// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches one- and two-word instructions from a synchronous
// instruction memory, presents them to the datapath, and sequences the PC
// through fall-through, jump, conditional skip and halt.
module fetch_sequencer #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            skip_next,
  output logic [31:0]     instr0,
  output logic [31:0]     instr1,
  output logic [3:0]      current_state,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  // Sequencer state encodings decoded by the datapath.
  typedef enum logic [3:0] {
    STATE_HALT   = 4'd0,
    STATE_FETCH0 = 4'd1,
    STATE_FETCH1 = 4'd2,
    STATE_FETCH2 = 4'd3,
    STATE_EXEC   = 4'd4,
    STATE_SKIP0  = 4'd5,
    STATE_SKIP1  = 4'd6
  } state_t;

  // Opcodes the sequencer itself needs to recognise (bits [31:24]).
  localparam logic [7:0] OP_END    = 8'h01;
  localparam logic [7:0] OP_LIMM16 = 8'h10;
  localparam logic [7:0] OP_LIMM32 = 8'h11;
  localparam logic [7:0] OP_LBSET  = 8'h20;

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [31:0]     instr0_r;
  logic [31:0]     instr1_r;
  logic [PC_W-1:0] exec_len_s;

  // Two-word instructions carry an immediate/extra word after the opcode word;
  // everything else, undefined opcodes included, is one word long.
  function automatic logic is_two_word(input logic [31:0] word);
    logic [7:0] opcode;
    opcode = word[31:24];
    return (opcode == OP_LIMM32) || (opcode == OP_LBSET);
  endfunction

  function automatic logic [PC_W-1:0] instr_len(input logic [31:0] word);
    return is_two_word(word) ? PC_W'(2'd2) : PC_W'(1'b1);
  endfunction

  assign exec_len_s = instr_len(instr0_r);

  // Memory read address: second word is read while the first is being latched.
  always_comb begin
    imem_addr = pc_r;
    case (state_r)
      STATE_FETCH1: imem_addr = pc_r + PC_W'(1'b1);
      default:      imem_addr = pc_r;
    endcase
  end

  // Main sequencer: state, PC and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= STATE_HALT;
      pc_r     <= '0;
      instr0_r <= 32'h0000_0000;
      instr1_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        STATE_HALT: begin
          if (start) begin
            pc_r    <= start_addr;
            state_r <= STATE_FETCH0;
          end
        end
        STATE_FETCH0: begin
          state_r <= STATE_FETCH1;
        end
        STATE_FETCH1: begin
          instr0_r <= imem_data;
          if (is_two_word(imem_data)) begin
            state_r <= STATE_FETCH2;
          end else begin
            instr1_r <= 32'h0000_0000;
            state_r  <= STATE_EXEC;
          end
        end
        STATE_FETCH2: begin
          instr1_r <= imem_data;
          state_r  <= STATE_EXEC;
        end
        STATE_EXEC: begin
          if (instr0_r[31:24] == OP_END) begin
            state_r <= STATE_HALT;
          end else if (jmp_en) begin
            pc_r    <= jmp_addr;
            state_r <= STATE_FETCH0;
          end else if (skip_next) begin
            pc_r    <= pc_r + exec_len_s;
            state_r <= STATE_SKIP0;
          end else begin
            pc_r    <= pc_r + exec_len_s;
            state_r <= STATE_FETCH0;
          end
        end
        STATE_SKIP0: begin
          state_r <= STATE_SKIP1;
        end
        STATE_SKIP1: begin
          // Step over the skipped instruction without ever presenting it.
          pc_r    <= pc_r + instr_len(imem_data);
          state_r <= STATE_FETCH0;
        end
        default: begin
          state_r <= STATE_HALT;
        end
      endcase
    end
  end

  assign instr0        = instr0_r;
  assign instr1        = instr1_r;
  assign pc            = pc_r;
  assign current_state = state_r;
  assign halted        = (state_r == STATE_HALT);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and control sequencer that sits directly upstream of the datapath. It reads one- and two-word instructions from a synchronous-read instruction memory and presents them as `instr0`/`instr1`. It drives the 4-bit `current_state` that the datapath decodes, and updates the PC after each execute cycle for fall-through, jump, conditional skip or halt.

## Interface
Parameters:
- `PC_W`, 16, PC and instruction-memory address width.

Ports:
- `clk`  in  1  system clock; the block has one clock and all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that leaves HALT and begins execution at `start_addr`.
- `start_addr`  in  PC_W  entry PC, sampled only with `start` while in HALT.
- `imem_addr`  out  PC_W  instruction-memory read address, combinational from state and PC.
- `imem_data`  in  32  memory read data, valid the cycle after `imem_addr`.
- `jmp_en`  in  1  taken-jump request from downstream, sampled only in EXEC.
- `jmp_addr`  in  PC_W  jump target, sampled with `jmp_en`.
- `skip_next`  in  1  conditional-skip request (CND false), sampled only in EXEC.
- `instr0`  out  32  first instruction word, registered.
- `instr1`  out  32  second instruction word; 0 for one-word instructions.
- `current_state`  out  4  sequencer state, feeds the datapath.
- `pc`  out  PC_W  address of the current instruction's first word.
- `halted`  out  1  high while in HALT.

## Operation
- States and encodings (shared `STATE_*` definitions): HALT=0, FETCH0=1, FETCH1=2, FETCH2=3, EXEC=4, SKIP0=5, SKIP1=6.
- Instruction length:
  - 2 words for `OP_LIMM32` and `OP_LBSET`.
  - 1 word for every other opcode, including undefined ones.
  - Opcode is bits [31:24] of the first word.
- `imem_addr`: `pc` in FETCH0 and SKIP0; `pc+1` in FETCH1; `pc` in all other states.
- HALT:
  - On `start`, `pc <= start_addr` and go to FETCH0.
  - Otherwise stay in HALT.
- FETCH0: issue read at `pc`; go to FETCH1.
- FETCH1: `instr0 <= imem_data`. Read at `pc+1` is issued in this state.
  - Two-word opcode: go to FETCH2.
  - Otherwise `instr1 <= 0` and go to EXEC.
- FETCH2: `instr1 <= imem_data`; go to EXEC.
- EXEC: exactly one cycle. Priority (highest first):
  1. `instr0` opcode is `OP_END`: go to HALT; `pc` unchanged.
  2. `jmp_en`: `pc <= jmp_addr`; go to FETCH0.
  3. `skip_next`: `pc <= pc + len`; go to SKIP0.
  4. Otherwise: `pc <= pc + len`; go to FETCH0.
- SKIP0: issue read at `pc` (the instruction being skipped); go to SKIP1.
- SKIP1: decode the length of `imem_data`; `pc <= pc + that length`; go to FETCH0. The skipped instruction is never presented in EXEC, so the datapath never executes it.
- `instr0`/`instr1` hold their values outside FETCH1/FETCH2.
- PC arithmetic is modulo 2^PC_W: `0xFFFF + 1 = 0x0000`, and a two-word instruction at `0xFFFF` reads its second word from `0x0000`.
- `start` outside HALT is ignored. `jmp_en` and `skip_next` outside EXEC are ignored.

## Timing
- Reset (asynchronous, immediate):
  - state HALT (`current_state=0`), `halted=1`
  - `pc=0`, `instr0=0`, `instr1=0`, `imem_addr=0`
- Reset mid-fetch or mid-skip aborts the instruction. No partial `instr0`/`instr1` survives; the block restarts only on a later `start`.
- `halted` is combinational from state: 1 only in HALT.
- Cycles per instruction, measured from FETCH0 to the next FETCH0:
  - one-word: 3 (FETCH0, FETCH1, EXEC)
  - two-word: 4 (FETCH0, FETCH1, FETCH2, EXEC)
  - plus 2 when a skip follows (SKIP0, SKIP1)
- First FETCH0 is the cycle after `start` is sampled.
- `instr0`, `instr1` and `pc` are stable for the whole EXEC cycle. The datapath's combinational outputs depend only on them and `current_state`.

## Test plan
- Reset and start: assert `reset` mid-cycle, then `start` with `start_addr=0x0010` -> outputs at reset values immediately; FETCH0 next cycle; `imem_addr=0x0010`.
- Mixed program: LIMM16, LIMM32 `0xDEADBEEF`, END at 0x0010 -> EXEC states at cycles 3, 7 and 10 after start. Second EXEC shows `instr1=0xDEADBEEF`. HALT is entered with `pc=0x0013`; `halted=1`.
- Jump: `jmp_en=1`, `jmp_addr=0x0100` during EXEC of a one-word instruction at 0x0020 -> next FETCH0 has `imem_addr=0x0100`. A `jmp_en` pulse during FETCH1 has no effect.
- Skip two-word: `skip_next=1` in EXEC at 0x0030 (one-word), with LBSET at 0x0031 -> SKIP0 reads 0x0031; next FETCH0 reads 0x0033. LBSET never appears in EXEC.
- Priority: `jmp_en` and `skip_next` both high in EXEC -> jump taken; no SKIP states. END with `jmp_en` high -> HALT with `pc` unchanged.
- Wrap: LIMM32 at `0xFFFF` -> second word read from `0x0000`; after EXEC, `pc=0x0001`.
